// File: rtl/gate_sweep_checker_pkg.sv
// gate_chk_pkg: shared definitions for the gate sweep checker.
//   state_e        - checker FSM state encoding
//   *_B            - bit positions of each gate inside the 7-bit result vector
//   NUM_VEC        - number of input combinations in one sweep of a two-input gate
package gate_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int NOT_B  = 6;
  localparam int NOR_B  = 5;
  localparam int OR_B   = 4;
  localparam int AND_B  = 3;
  localparam int NAND_B = 2;
  localparam int XOR_B  = 1;
  localparam int XNOR_B = 0;

  localparam int NUM_VEC = 4;

endpackage

// File: rtl/gate_sweep_checker_if.sv
// gate_sweep_checker_if: bus between the checker and the two-input gate block.
//   a, b      - stimulus, driven by the checker
//   *_g       - the seven gate outputs, driven by the gate block
// Modports: master = checker side, slave = gate block side.
// Handshake: none; the bus is a plain combinational path. The checker holds
// a,b stable for the settle window and samples the gate outputs only in CHECK.
interface gate_sweep_checker_if;
  logic a;
  logic b;
  logic not_g;
  logic nor_g;
  logic or_g;
  logic and_g;
  logic nand_g;
  logic xor_g;
  logic xnor_g;

  modport master (
    output a, b,
    input  not_g, nor_g, or_g, and_g, nand_g, xor_g, xnor_g
  );

  modport slave (
    input  a, b,
    output not_g, nor_g, or_g, and_g, nand_g, xor_g, xnor_g
  );
endinterface

// File: rtl/gate_sweep_checker_ref_model.sv
// gate_ref_model: golden combinational model of the two-input gate block.
//   a, b    - gate inputs
//   exp_o   - expected outputs, bit order not/nor/or/and/nand/xor/xnor (6..0)
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [6:0] exp_o
);

  always_comb begin
    exp_o         = '0;
    exp_o[NOT_B]  = ~a;
    exp_o[NOR_B]  = ~(a | b);
    exp_o[OR_B]   = a | b;
    exp_o[AND_B]  = a & b;
    exp_o[NAND_B] = ~(a & b);
    exp_o[XOR_B]  = a ^ b;
    exp_o[XNOR_B] = ~(a ^ b);
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: drives a two-input gate block through all input
// combinations, checks its seven outputs against gate_ref_model and reports
// the outcome.
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   start       - one-cycle pulse, accepted in IDLE or DONE, ignored while busy
//   gif         - gate bus (master): a,b out, seven gate outputs in
//   busy        - sweep in progress
//   done        - sweep finished; pass/err_count/fail_vec are final
//   pass        - no vector mismatched (valid while done)
//   err_count   - vectors with at least one bad gate, saturating
//   fail_vec    - sticky per-gate mismatch flags, not/nor/or/and/nand/xor/xnor
//   state_dbg   - current FSM state, for observation only
module gate_sweep_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  gate_sweep_checker_if.master gif,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [6:0]           fail_vec,
  output logic [1:0]           state_dbg
);

  localparam logic [1:0] IDLE   = 2'(S_IDLE);
  localparam logic [1:0] SETTLE = 2'(S_SETTLE);
  localparam logic [1:0] CHECK  = 2'(S_CHECK);
  localparam logic [1:0] DONE   = 2'(S_DONE);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PASS_LAST   = 4'(NUM_PASSES - 1);
  localparam logic [1:0] VEC_LAST    = 2'(NUM_VEC - 1);

  logic [1:0]       state_q, state_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d, err_next;
  logic [6:0]       fail_q, fail_d;
  logic [1:0]       vec_q, vec_d;
  logic [3:0]       pass_idx_q, pass_idx_d;
  logic [3:0]       settle_q, settle_d;
  logic [6:0]       exp_v, got_v, mism;

  gate_ref_model u_ref (
    .a     (a_q),
    .b     (b_q),
    .exp_o (exp_v)
  );

  assign got_v = {gif.not_g, gif.nor_g, gif.or_g, gif.and_g,
                  gif.nand_g, gif.xor_g, gif.xnor_g};
  assign mism  = exp_v ^ got_v;

  // Count stops at all-ones so the number never wraps back toward zero.
  assign err_next = (|mism && (err_q != '1)) ? err_q + 1'b1 : err_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    fail_d     = fail_q;
    vec_d      = vec_q;
    pass_idx_d = pass_idx_q;
    settle_d   = settle_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = SETTLE;
          a_d        = 1'b0;
          b_d        = 1'b0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_d      = '0;
          fail_d     = '0;
          vec_d      = '0;
          pass_idx_d = '0;
          settle_d   = '0;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      CHECK: begin
        fail_d = fail_q | mism;
        err_d  = err_next;
        if (vec_q == VEC_LAST && pass_idx_q == PASS_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else if (vec_q == VEC_LAST) begin
          state_d    = SETTLE;
          vec_d      = '0;
          pass_idx_d = pass_idx_q + 1'b1;
          a_d        = 1'b0;
          b_d        = 1'b0;
        end else begin
          state_d    = SETTLE;
          vec_d      = vec_q + 1'b1;
          // Vector index doubles as the {a,b} pattern: 00, 01, 10, 11.
          {a_d, b_d} = vec_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_q     <= '0;
      vec_q      <= '0;
      pass_idx_q <= '0;
      settle_q   <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
      vec_q      <= vec_d;
      pass_idx_q <= pass_idx_d;
      settle_q   <= settle_d;
    end
  end

  assign gif.a     = a_q;
  assign gif.b     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
  assign state_dbg = state_q;

endmodule
